// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receiver with receive FIFO.
// The PARITY state exists only when UART_RX_PARITY_EN is defined.
package uart_pkg;

  localparam int DEFAULT_BIT_PERIOD = 1250;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } rx_state_e;

  // Expected parity bit: XOR of the data, inverted for odd parity.
  function automatic logic calc_parity(input logic [7:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Power-of-two synchronous FIFO with first-word fall-through read.
// Storage is deliberately left unreset; only pointers and count are cleared.
module sync_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          push,
  input  logic [DATA_BITS-1:0]          push_data,
  input  logic                          pop,
  output logic [DATA_BITS-1:0]          pop_data,
  output logic                          empty,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_C = CW'(FIFO_DEPTH);

  logic [DATA_BITS-1:0] mem_r [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_r;
  logic [AW-1:0]        rd_ptr_r;
  logic [CW-1:0]        count_r;
  logic                 do_push_s;
  logic                 do_pop_s;

  // A push into a full FIFO is accepted only when a pop frees a slot on the same edge.
  always_comb begin
    do_pop_s  = pop && (count_r != {CW{1'b0}});
    do_push_s = push && ((count_r != FULL_C) || do_pop_s);
  end

  // Entry storage.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign pop_data = mem_r[rd_ptr_r];
  assign empty    = (count_r == {CW{1'b0}});
  assign full     = (count_r == FULL_C);
  assign count    = count_r;

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver with false-start rejection, framing/overrun detection and a receive FIFO.
// Optional parity checking is compiled in with the UART_RX_PARITY_EN macro.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int BIT_PERIOD = DEFAULT_BIT_PERIOD,
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int PARITY_ODD = 0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          rx_pin,
  input  logic                          rd_en,
  output logic [DATA_BITS-1:0]          rd_data,
  output logic                          empty,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  input  logic                          clr_err,
  output logic                          frame_err,
  output logic                          overrun,
  output logic                          parity_err
);

  localparam int TW = $clog2(BIT_PERIOD);
  localparam logic [TW-1:0] FULL_T   = TW'(BIT_PERIOD - 1);
  localparam logic [TW-1:0] HALF_T   = TW'(BIT_PERIOD / 2 - 2);
  localparam logic [3:0]    LAST_BIT = 4'(DATA_BITS - 1);

  if (BIT_PERIOD < 4 || DATA_BITS < 5 || DATA_BITS > 8 || FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_params
    $error("uart_rx_fifo: illegal parameter set");
  end

  logic                 sync1_r;
  logic                 rxs_r;
  rx_state_e            state_r;
  logic [TW-1:0]        timer_r;
  logic [3:0]           bit_cnt_r;
  logic [DATA_BITS-1:0] shift_r;
  logic                 push_r;
  logic                 frame_err_r;
  logic                 overrun_r;
  logic                 bit_tick_s;
  logic                 half_tick_s;
  logic                 frame_set_s;
  logic                 overrun_set_s;
`ifdef UART_RX_PARITY_EN
  logic                 par_bad_r;
  logic                 parity_err_r;
  logic                 parity_set_s;
`endif

  // Two-flop synchroniser; idles high so reset never looks like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 1'b1;
      rxs_r   <= 1'b1;
    end else begin
      sync1_r <= rx_pin;
      rxs_r   <= sync1_r;
    end
  end

  // Sample strobes and error-set events.
  always_comb begin
    bit_tick_s    = (timer_r == FULL_T);
    half_tick_s   = (timer_r == HALF_T);
    frame_set_s   = (state_r == ST_STOP) && bit_tick_s && !rxs_r;
    overrun_set_s = push_r && full && !rd_en;
`ifdef UART_RX_PARITY_EN
    parity_set_s  = (state_r == ST_STOP) && bit_tick_s && rxs_r && par_bad_r;
`endif
  end

  // Receive FSM; the timer restarts at every sample so samples sit one bit period apart.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      timer_r   <= {TW{1'b0}};
      bit_cnt_r <= 4'd0;
      shift_r   <= {DATA_BITS{1'b0}};
      push_r    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_r <= 1'b0;
`endif
    end else begin
      push_r  <= 1'b0;
      timer_r <= timer_r + TW'(1);
      case (state_r)
        ST_IDLE: begin
          timer_r <= {TW{1'b0}};
          if (!rxs_r) begin
            bit_cnt_r <= 4'd0;
            state_r   <= ST_START;
          end
        end
        ST_START: begin
          if (half_tick_s) begin
            timer_r <= {TW{1'b0}};
            state_r <= rxs_r ? ST_IDLE : ST_DATA;
          end
        end
        ST_DATA: begin
          if (bit_tick_s) begin
            timer_r   <= {TW{1'b0}};
            shift_r   <= {rxs_r, shift_r[DATA_BITS-1:1]};
            bit_cnt_r <= bit_cnt_r + 4'd1;
            if (bit_cnt_r == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
              state_r <= ST_PARITY;
`else
              state_r <= ST_STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (bit_tick_s) begin
            timer_r   <= {TW{1'b0}};
            par_bad_r <= (rxs_r != calc_parity(8'(shift_r), 1'(PARITY_ODD)));
            state_r   <= ST_STOP;
          end
        end
`endif
        ST_STOP: begin
          if (bit_tick_s) begin
            timer_r <= {TW{1'b0}};
            if (!rxs_r) begin
              state_r <= ST_BREAK;
            end else begin
              state_r <= ST_IDLE;
`ifdef UART_RX_PARITY_EN
              push_r  <= !par_bad_r;
`else
              push_r  <= 1'b1;
`endif
            end
          end
        end
        ST_BREAK: begin
          if (rxs_r) begin
            state_r <= ST_IDLE;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  // Sticky error flags; a set event beats a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_err_r  <= 1'b0;
      overrun_r    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_r <= 1'b0;
`endif
    end else begin
      if (frame_set_s)        frame_err_r <= 1'b1;
      else if (clr_err)       frame_err_r <= 1'b0;
      else                    frame_err_r <= frame_err_r;
      if (overrun_set_s)      overrun_r   <= 1'b1;
      else if (clr_err)       overrun_r   <= 1'b0;
      else                    overrun_r   <= overrun_r;
`ifdef UART_RX_PARITY_EN
      if (parity_set_s)       parity_err_r <= 1'b1;
      else if (clr_err)       parity_err_r <= 1'b0;
      else                    parity_err_r <= parity_err_r;
`endif
    end
  end

  assign frame_err = frame_err_r;
  assign overrun   = overrun_r;
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_r;
`else
  assign parity_err = 1'b0;
`endif

  sync_fifo #(
    .DATA_BITS  (DATA_BITS),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_r),
    .push_data (shift_r),
    .pop       (rd_en),
    .pop_data  (rd_data),
    .empty     (empty),
    .full      (full),
    .count     (count)
  );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo at BIT_PERIOD=16, 8 data bits, 16 entries.
// Parity scenarios are included when UART_RX_PARITY_EN is defined.
module tb_uart_rx_fifo;
  import uart_pkg::*;

  localparam int BP = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx_pin;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       empty;
  logic       full;
  logic [4:0] count;
  logic       clr_err;
  logic       frame_err;
  logic       overrun;
  logic       parity_err;

  int n_cmp = 0;
  int n_err = 0;

  uart_rx_fifo #(
    .BIT_PERIOD (BP),
    .DATA_BITS  (8),
    .FIFO_DEPTH (16),
    .PARITY_ODD (0)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_pin     (rx_pin),
    .rd_en      (rd_en),
    .rd_data    (rd_data),
    .empty      (empty),
    .full       (full),
    .count      (count),
    .clr_err    (clr_err),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bit_out(input logic v);
    rx_pin = v;
    tick(BP);
  endtask

  // One frame; optionally pops on the exact cycle the receiver pushes.
  task automatic send(input logic [7:0] d, input logic stop_bit, input logic par_bit,
                      input logic pop_on_push, output logic saw_push);
    saw_push = 1'b0;
    bit_out(1'b0);
    for (int i = 0; i < 8; i++) bit_out(d[i]);
`ifdef UART_RX_PARITY_EN
    bit_out(par_bit);
`else
    if (par_bit === 1'bx) $display("note: parity bit ignored");
`endif
    rx_pin = stop_bit;
    for (int c = 0; c < BP; c++) begin
      rd_en = pop_on_push && dut.push_r;
      if (dut.push_r) saw_push = 1'b1;
      tick(1);
    end
    rd_en = 1'b0;
  endtask

  task automatic send_ok(input logic [7:0] d);
    logic seen;
    send(d, 1'b1, ^d, 1'b0, seen);
  endtask

  task automatic pop_chk(input string tag, input logic [7:0] exp);
    chk(tag, 32'(rd_data), 32'(exp));
    rd_en = 1'b1;
    tick(1);
    rd_en = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
  endtask

  initial begin
    logic seen;
    rst_n = 1'b0; rx_pin = 1'b1; rd_en = 1'b0; clr_err = 1'b0;
    tick(3);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_errs", {29'd0, frame_err, overrun, parity_err}, 32'd0);
    rst_n = 1'b1;
    tick(4);

    // back-to-back frames
    send_ok(8'h31); send_ok(8'h0D); send_ok(8'h20);
    tick(4);
    chk("b2b_count", 32'(count), 32'd3);
    pop_chk("b2b_pop0", 8'h31);
    pop_chk("b2b_pop1", 8'h0D);
    pop_chk("b2b_pop2", 8'h20);
    chk("b2b_empty", 32'(empty), 32'd1);

    // false start
    rx_pin = 1'b0; tick(4); rx_pin = 1'b1; tick(3 * BP);
    chk("glitch_count", 32'(count), 32'd0);
    chk("glitch_idle", 32'(dut.state_r), 32'(ST_IDLE));
    chk("glitch_ferr", 32'(frame_err), 32'd0);

    // framing error followed by a held-low line
    send(8'h55, 1'b0, 1'b0, 1'b0, seen);
    chk("ferr_set", 32'(frame_err), 32'd1);
    chk("ferr_count", 32'(count), 32'd0);
    pulse_clr();
    rx_pin = 1'b0; tick(5 * BP); rx_pin = 1'b1; tick(2 * BP);
    chk("ferr_once", 32'(frame_err), 32'd0);
    chk("ferr_nobyte", 32'(count), 32'd0);
    send_ok(8'hA5);
    chk("after_brk_count", 32'(count), 32'd1);
    pop_chk("after_brk_data", 8'hA5);

    // fill, then overrun
    for (int i = 0; i < 16; i++) send_ok(8'(16 + i));
    chk("fill_count", 32'(count), 32'd16);
    chk("fill_full", 32'(full), 32'd1);
    send_ok(8'h7E);
    chk("ovr_set", 32'(overrun), 32'd1);
    chk("ovr_count", 32'(count), 32'd16);
    chk("ovr_head", 32'(rd_data), 32'h10);
    pulse_clr();
    chk("ovr_clr", 32'(overrun), 32'd0);

    // push and pop on the same edge while full
    send(8'h42, 1'b1, 1'b0, 1'b1, seen);
    chk("pp_seen", 32'(seen), 32'd1);
    chk("pp_count", 32'(count), 32'd16);
    chk("pp_ovr", 32'(overrun), 32'd0);
    for (int i = 1; i < 16; i++) pop_chk("pp_drain", 8'(16 + i));
    pop_chk("pp_last", 8'h42);
    chk("drain_empty", 32'(empty), 32'd1);
    rd_en = 1'b1; tick(1); rd_en = 1'b0;
    chk("pop_empty_count", 32'(count), 32'd0);
    chk("pop_empty_flag", 32'(empty), 32'd1);

`ifdef UART_RX_PARITY_EN
    send(8'h03, 1'b1, 1'b1, 1'b0, seen);
    chk("par_bad_flag", 32'(parity_err), 32'd1);
    chk("par_bad_drop", 32'(count), 32'd0);
    pulse_clr();
    send(8'h03, 1'b1, 1'b0, 1'b0, seen);
    chk("par_ok_flag", 32'(parity_err), 32'd0);
    chk("par_ok_count", 32'(count), 32'd1);
    pop_chk("par_ok_data", 8'h03);
`else
    chk("par_tied", 32'(parity_err), 32'd0);
`endif

    // reset in the middle of a frame flushes the FIFO
    send_ok(8'h99);
    chk("mid_pre_count", 32'(count), 32'd1);
    rx_pin = 1'b0; tick(3 * BP);
    rst_n = 1'b0; tick(1);
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_empty", 32'(empty), 32'd1);
    rx_pin = 1'b1; tick(1); rst_n = 1'b1; tick(2 * BP);
    chk("mid_rst_idle", 32'(dut.state_r), 32'(ST_IDLE));
    send_ok(8'h5A);
    chk("mid_rec_count", 32'(count), 32'd1);
    pop_chk("mid_rec_data", 8'h5A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
